// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART definitions: FSM state encoding and the line levels
//            used for idle and start bits. Intended for reuse by uart_rx.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Transmit/receive frame states; PARITY is only reachable when parity is
   // built in.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SYNC   = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } uart_state_t;

   // Line level while idle and during stop bits (mark).
   localparam logic C_LINE_IDLE  = 1'b1;
   // Line level of the start bit (space).
   localparam logic C_LINE_START = 1'b0;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : UART transmitter. Accepts a word on a valid/ready handshake,
//            waits for the next baud tick so the start bit is tick aligned,
//            then sends start, DATA_BITS data bits LSB first, optional even
//            parity and STOP_BITS stop bits. Each bit lasts one tick period.
//            Optional feature macro: UART_TX_PARITY_EN (adds the even parity
//            bit after the data bits).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_tick,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic                 o_tx,
   output logic                 o_busy
);

   localparam int                 C_CNT_W     = $clog2(DATA_BITS);
   localparam logic [C_CNT_W-1:0] C_LAST_BIT  = C_CNT_W'(DATA_BITS - 1);
   localparam logic               C_LAST_STOP = 1'(STOP_BITS - 1);

   uart_state_t          r_state    = ST_IDLE;
   logic [DATA_BITS-1:0] r_shift    = '0;
   logic [C_CNT_W-1:0]   r_bit_cnt  = '0;
   logic                 r_stop_cnt = 1'b0;
   logic                 r_tx       = C_LINE_IDLE;

   uart_state_t          w_state_nxt;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic [C_CNT_W-1:0]   w_bit_cnt_nxt;
   logic                 w_stop_cnt_nxt;
   logic                 w_tx_nxt;

`ifdef UART_TX_PARITY_EN
   // Parity is captured with the word so the shift register can be consumed.
   logic                 r_parity = 1'b0;
   logic                 w_parity_nxt;
`endif

   // State register and datapath registers; reset wins over everything.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_tx       <= C_LINE_IDLE;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_stop_cnt <= w_stop_cnt_nxt;
         r_tx       <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
         r_parity   <= w_parity_nxt;
`endif
      end
   end

   // Next-state and next line level; the line value is decided one cycle
   // ahead so o_tx comes straight from a flop.
   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_stop_cnt_nxt = r_stop_cnt;
      w_tx_nxt       = r_tx;
`ifdef UART_TX_PARITY_EN
      w_parity_nxt   = r_parity;
`endif
      case (r_state)
         ST_IDLE: begin
            // Ticks are ignored here; a tick on the accept cycle does not
            // count towards SYNC because SYNC is not yet the current state.
            w_tx_nxt = C_LINE_IDLE;
            if (i_valid) begin
               w_state_nxt    = ST_SYNC;
               w_shift_nxt    = i_data;
               w_bit_cnt_nxt  = '0;
               w_stop_cnt_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
               w_parity_nxt   = ^i_data;
`endif
            end
         end
         ST_SYNC: begin
            if (i_tick) begin
               w_state_nxt = ST_START;
               w_tx_nxt    = C_LINE_START;
            end
         end
         ST_START: begin
            if (i_tick) begin
               w_state_nxt = ST_DATA;
               w_tx_nxt    = r_shift[0];
               w_shift_nxt = r_shift >> 1;
            end
         end
         ST_DATA: begin
            if (i_tick) begin
               if (r_bit_cnt == C_LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = ST_PARITY;
                  w_tx_nxt    = r_parity;
`else
                  w_state_nxt = ST_STOP;
                  w_tx_nxt    = C_LINE_IDLE;
`endif
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + C_CNT_W'(1);
                  w_tx_nxt      = r_shift[0];
                  w_shift_nxt   = r_shift >> 1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (i_tick) begin
               w_state_nxt = ST_STOP;
               w_tx_nxt    = C_LINE_IDLE;
            end
         end
`endif
         ST_STOP: begin
            if (i_tick) begin
               if (r_stop_cnt == C_LAST_STOP) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_stop_cnt_nxt = r_stop_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = C_LINE_IDLE;
         end
      endcase
   end

   assign o_tx    = r_tx;
   assign o_ready = (r_state == ST_IDLE);
   assign o_busy  = (r_state != ST_IDLE);

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx. Two instances: 1 stop bit and
//            2 stop bits. Stimulus queues expected frames; one monitor per
//            instance pops a frame on each start bit and checks every bit,
//            its duration, busy during the frame and ready afterwards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

   typedef struct {
      logic [15:0] bits;    // line levels in transmission order
      int          nbits;
      int          period;  // cycles per bit
      int          lat;     // cycles from handshake edge to start bit, -1 = unchecked
      bit          abort;   // frame is expected to be cut short by reset
      logic        par;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       tick_high = 1'b0;
   logic [1:0] valid = 2'b00;
   logic [7:0] data_in [2];
   logic [1:0] tx_w;
   logic [1:0] ready_w;
   logic [1:0] busy_w;

   frame_t exp_q [2][$];
   int     pushed [2];
   int     done   [2];
   int     hs_cnt [2];
   int     hs_cyc [2];
   int     cyc = 0;
   int     checks = 0;
   int     failures = 0;

   always #5 clk = ~clk;

   uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) u_dut0 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_tick  (tick),
      .i_data  (data_in[0]),
      .i_valid (valid[0]),
      .o_ready (ready_w[0]),
      .o_tx    (tx_w[0]),
      .o_busy  (busy_w[0])
   );

   uart_tx #(.DATA_BITS(8), .STOP_BITS(2)) u_dut1 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_tick  (tick),
      .i_data  (data_in[1]),
      .i_valid (valid[1]),
      .o_ready (ready_w[1]),
      .o_tx    (tx_w[1]),
      .o_busy  (busy_w[1])
   );

   // Cycle counter.
   always @(posedge clk) cyc = cyc + 1;

   // Baud tick: one cycle in four, or constantly high when requested.
   initial begin
      int div;
      div = 0;
      forever begin
         @(posedge clk);
         #1;
         div  = (div + 1) % 4;
         tick = tick_high || (div == 0);
      end
   end

   // Handshake recorder: valid&ready seen here completes on the next edge.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (!rst && valid[g] && ready_w[g]) begin
            hs_cnt[g] = hs_cnt[g] + 1;
            hs_cyc[g] = cyc + 1;
         end
      end
   end

   function automatic frame_t make_frame(input logic [7:0] d, input logic par,
                                         input int stops, input int period,
                                         input int lat, input bit abort);
      frame_t f;
      int     n;
      f.bits = '1;
      n = 0;
      f.bits[n] = 1'b0;
      n++;
      for (int i = 0; i < 8; i++) begin
         f.bits[n] = d[i];
         n++;
      end
`ifdef UART_TX_PARITY_EN
      f.bits[n] = par;
      n++;
`endif
      for (int i = 0; i < stops; i++) begin
         f.bits[n] = 1'b1;
         n++;
      end
      f.nbits  = n;
      f.period = period;
      f.lat    = lat;
      f.abort  = abort;
      f.par    = par;
      return f;
   endfunction

   // One monitor per instance.
   for (genvar g = 0; g < 2; g++) begin : g_mon
      initial begin
         frame_t f;
         bit     bad;
         bit     aborted;
         logic   seen;
         forever begin
            @(negedge clk);
            if (!rst && tx_w[g] == 1'b0) begin
               if (exp_q[g].size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL dut%0d_unexpected_start: line=%b with no frame queued, want 1", g, tx_w[g]);
                  while (tx_w[g] == 1'b0) @(negedge clk);
               end else begin
                  f = exp_q[g].pop_front();
                  if (f.lat >= 0) begin
                     checks++;
                     if (cyc - hs_cyc[g] != f.lat) begin
                        failures++;
                        $display("FAIL dut%0d_start_latency: got %0d cycles, want %0d", g, cyc - hs_cyc[g], f.lat);
                     end
                  end
                  aborted = 1'b0;
                  for (int b = 0; b < f.nbits && !aborted; b++) begin
                     bad  = 1'b0;
                     seen = f.bits[b];
                     for (int c = 0; c < f.period; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst) begin
                           aborted = 1'b1;
                           break;
                        end
                        if (tx_w[g] !== f.bits[b] || busy_w[g] !== 1'b1) begin
                           bad  = 1'b1;
                           seen = tx_w[g];
                        end
                     end
                     if (!aborted) begin
                        checks++;
                        if (bad) begin
                           failures++;
                           $display("FAIL dut%0d_bit%0d: line=%b busy=%b, want line=%b busy=1 for %0d cycles",
                                    g, b, seen, busy_w[g], f.bits[b], f.period);
                        end
                     end
                  end
                  checks++;
                  if (aborted) begin
                     if (!f.abort) begin
                        failures++;
                        $display("FAIL dut%0d_abort: frame cut by reset, want complete frame", g);
                     end
                  end else begin
                     @(negedge clk);
                     if (ready_w[g] !== 1'b1 || busy_w[g] !== 1'b0 || f.abort) begin
                        failures++;
                        $display("FAIL dut%0d_end_of_frame: ready=%b busy=%b aborted=0, want ready=1 busy=0 aborted=%0d",
                                 g, ready_w[g], busy_w[g], f.abort);
                     end
                  end
                  done[g]++;
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic wait_ready(input int g);
      int n;
      n = 0;
      while (ready_w[g] !== 1'b1 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (ready_w[g] !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL dut%0d_ready_timeout: ready=%b after %0d cycles, want 1", g, ready_w[g], n);
      end
   endtask

   task automatic send(input int g, input logic [7:0] d, input logic par,
                       input int stops, input int period, input int lat, input bit abort);
      wait_ready(g);
      exp_q[g].push_back(make_frame(d, par, stops, period, lat, abort));
      pushed[g]++;
      data_in[g] = d;
      valid[g]   = 1'b1;
      @(posedge clk);
      #1;
      valid[g]   = 1'b0;
      data_in[g] = 8'h00;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((done[0] != pushed[0] || done[1] != pushed[1]) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (done[0] != pushed[0] || done[1] != pushed[1]) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: done=%0d/%0d, want %0d/%0d", done[0], done[1], pushed[0], pushed[1]);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hs0;
      int n;
      for (int g = 0; g < 2; g++) begin
         data_in[g] = 8'h00;
         pushed[g]  = 0;
         done[g]    = 0;
         hs_cnt[g]  = 0;
         hs_cyc[g]  = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_tx0",    {7'd0, tx_w[0]},    8'h01);
      check("reset_ready0", {7'd0, ready_w[0]}, 8'h01);
      check("reset_busy0",  {7'd0, busy_w[0]},  8'h00);
      check("reset_tx1",    {7'd0, tx_w[1]},    8'h01);
      check("reset_ready1", {7'd0, ready_w[1]}, 8'h01);
      check("reset_busy1",  {7'd0, busy_w[1]},  8'h00);
      @(posedge clk);
      #1;

      // Plain frames: 0x55 alternates, 0x07 has odd parity, 0x03 even.
      send(0, 8'h55, 1'b0, 1, 4, -1, 1'b0);
      send(0, 8'h07, 1'b1, 1, 4, -1, 1'b0);
      send(0, 8'h03, 1'b0, 1, 4, -1, 1'b0);
      drain();

      // Back-to-back with valid held: second start on first tick after stop.
      wait_ready(0);
      exp_q[0].push_back(make_frame(8'hA5, 1'b0, 1, 4, -1, 1'b0));
      exp_q[0].push_back(make_frame(8'h3C, 1'b0, 1, 4, 3, 1'b0));
      pushed[0] += 2;
      hs0 = hs_cnt[0];
      data_in[0] = 8'hA5;
      valid[0]   = 1'b1;
      @(posedge clk);
      #1;
      data_in[0] = 8'h3C;
      n = 0;
      while (hs_cnt[0] - hs0 < 2 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      valid[0]   = 1'b0;
      data_in[0] = 8'h00;
      drain();
      check("b2b_handshakes", 8'(hs_cnt[0] - hs0), 8'd2);

      // Reset during data bit 3 of 0xFF, then a clean 0x81.
      send(0, 8'hFF, 1'b0, 1, 4, -1, 1'b1);
      n = 0;
      while (tx_w[0] !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("abort_start_seen", {7'd0, tx_w[0]}, 8'h00);
      repeat (17) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midreset_tx",    {7'd0, tx_w[0]},    8'h01);
      check("midreset_ready", {7'd0, ready_w[0]}, 8'h01);
      check("midreset_busy",  {7'd0, busy_w[0]},  8'h00);
      @(posedge clk);
      #1;
      send(0, 8'h81, 1'b0, 1, 4, -1, 1'b0);
      drain();

      // Tick tied high: one cycle per bit, SYNC lasts exactly one cycle.
      tick_high = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      send(0, 8'h80, 1'b1, 1, 1, 1, 1'b0);
      drain();
      tick_high = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Two stop bits on the second instance.
      send(1, 8'h00, 1'b0, 2, 4, -1, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_uart_tx
`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, is the number of data bits per frame; the legal range is 5..9.
REQ-002 Parameter STOP_BITS, default 1, is the number of stop bits per frame; the legal values are 1 and 2.
REQ-003 i_clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_tick  input  1  one-cycle baud enable from the upstream divider; high for exactly one i_clk cycle per bit period.
REQ-006 i_data  input  DATA_BITS  byte to transmit; sampled only on handshake.
REQ-007 i_valid  input  1  producer has i_data available.
REQ-008 o_ready  output  1  block can accept a byte; high only in IDLE.
REQ-009 o_tx  output  1  serial line; idle level is 1; registered output, no combinational path from any input.
REQ-010 o_busy  output  1  high in every state except IDLE.

Function
REQ-011 The block SHALL implement the states IDLE, SYNC, START, DATA, PARITY, STOP.
REQ-012 A transfer SHALL occur on any rising edge where i_valid=1 and o_ready=1: i_data is captured into the shift register, the state goes to SYNC, and o_ready=0 from the next cycle.
REQ-013 SYNC SHALL wait for the next i_tick; on that tick the state goes to START and o_tx=0 from the following cycle, aligning the start bit to the tick phase.
REQ-014 Each of START, DATA, PARITY and STOP SHALL advance only on a cycle with i_tick=1, so that every bit is held for exactly one tick period.
REQ-015 Data bits SHALL be sent LSB first; a bit counter of width $clog2(DATA_BITS) counts 0..DATA_BITS-1 and leaves DATA when it reaches DATA_BITS-1 on a tick.
REQ-016 STOP SHALL drive o_tx=1 for STOP_BITS tick periods; on the final stop tick the state goes to IDLE, with o_ready=1 and o_busy=0 from the next cycle.
REQ-017 While in IDLE, i_tick SHALL be ignored.
REQ-018 While not in IDLE, i_valid SHALL be ignored and i_data may change freely.
REQ-019 If i_tick=1 on the acceptance cycle, that tick SHALL NOT advance SYNC; the frame starts on the next tick.
REQ-020 Back-to-back frames: a byte accepted on the first IDLE cycle SHALL start its frame on the next tick, giving no extra idle bit beyond the configured stop bits plus the SYNC wait.
REQ-021 If i_tick is held high continuously, each bit SHALL last exactly one i_clk cycle.

Reset
REQ-022 On i_rst=1 the block SHALL set state=IDLE, o_tx=1, o_ready=1, o_busy=0, and clear the bit counter and shift register on the next edge, including mid-frame.
REQ-023 i_rst SHALL take priority over i_valid and i_tick on the same cycle.
REQ-024 Initial values SHALL match the reset values.

Configuration
REQ-025 With macro UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA and drive the even-parity bit (XOR of all data bits) for one tick period.
REQ-026 Without UART_TX_PARITY_EN, DATA SHALL go directly to STOP, and no parity logic SHALL be synthesised.

Structure
REQ-027 The state enumeration, idle line level (1), and start bit level (0) SHALL live in the shared package uart_pkg, to be reused by a future uart_rx.
REQ-028 uart_tx SHALL be a single module with no sub-modules; the tick comes from the existing clock divider instance in the parent.

Verification
REQ-029 Bench setup: i_tick pulses every 4 cycles, DATA_BITS=8, STOP_BITS=1, no parity; send 0x55 -> o_tx reads 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles, then o_ready=1.
REQ-030 With UART_TX_PARITY_EN, send 0x07 -> the parity bit is 1 and the frame is 11 bits long; send 0x03 -> the parity bit is 0.
REQ-031 Hold i_valid high with 0xA5 then 0x3C -> two frames are sent, the second start bit begins on the first tick after the first stop bit, and exactly two handshakes occur.
REQ-032 Assert i_rst during data bit 3 of 0xFF -> on the next cycle o_tx=1, o_ready=1, o_busy=0; a subsequent send of 0x81 is correct.
REQ-033 i_tick tied high, send 0x80 -> o_tx is 0,0,0,0,0,0,0,0,1,1 on consecutive cycles after the SYNC cycle.
REQ-034 STOP_BITS=2, send 0x00 -> the line stays high for 2 tick periods before o_ready rises.
